// File: rtl/tlb_refill_pkg.sv
// Shared geometry, PTE field layout and FSM encodings for the TLB refill path.
package tlb_refill_pkg;

  localparam int NUM_WAYS       = 4;
  localparam int SET_INDEX_BITS = 4;
  localparam int NUM_SETS       = 2 ** SET_INDEX_BITS;
  localparam int WAY_BITS       = 2;
  localparam int VPN_BITS       = 20;
  localparam int PPN_BITS       = 20;
  localparam int PERM_BITS      = 2;
  localparam int ENTRY_BITS     = SET_INDEX_BITS + WAY_BITS;

  localparam int PPN_MSB  = 31;
  localparam int PPN_LSB  = 12;
  localparam int PERM_MSB = 2;
  localparam int PERM_LSB = 1;
  localparam int PTE_V    = 0;

  localparam logic [ENTRY_BITS-1:0] ENTRY_LAST = ENTRY_BITS'(NUM_SETS * NUM_WAYS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  typedef struct packed {
    logic [PPN_BITS-1:0]  ppn;
    logic [PERM_BITS-1:0] perms;
    logic                 valid;
  } pte_t;

endpackage

// File: rtl/tlb_refill_victim_sel.sv
// Victim way choice: lowest invalid way, else per-set round-robin pointer.
module tlb_refill_victim_sel
  import tlb_refill_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SET_INDEX_BITS-1:0] set_i,
  input  logic [NUM_WAYS-1:0]       set_valid_i,
  input  logic                      commit_i,
  input  logic                      clear_i,
  output logic [WAY_BITS-1:0]       way_o
);

  logic [WAY_BITS-1:0] rr_q [NUM_SETS];
  logic [WAY_BITS-1:0] rr_d [NUM_SETS];
  logic [WAY_BITS-1:0] first_inv;
  logic                all_valid;

  // Descending scan so the lowest invalid index wins.
  always_comb begin
    first_inv = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!set_valid_i[i]) begin
        first_inv = WAY_BITS'(i);
      end else begin
        first_inv = first_inv;
      end
    end
    all_valid = &set_valid_i;
    way_o     = all_valid ? rr_q[set_i] : first_inv;
  end

  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      rr_d[s] = clear_i ? '0 : rr_q[s];
    end
    if (!clear_i && commit_i && all_valid) begin
      rr_d[set_i] = rr_q[set_i] + WAY_BITS'(1);
    end else begin
      rr_d[set_i] = rr_d[set_i];
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SETS; s++) begin
      if (!rst_n) begin
        rr_q[s] <= '0;
      end else begin
        rr_q[s] <= rr_d[s];
      end
    end
  end

endmodule

// File: rtl/tlb_refill.sv
// TLB refill engine: miss -> PTW request -> PTE write, plus sequential full flush.
module tlb_refill
  import tlb_refill_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      miss_valid_i,
  input  logic [VPN_BITS-1:0]       miss_vpn_i,
  output logic                      miss_ready_o,
  input  logic [NUM_WAYS-1:0]       set_valid_i,
  input  logic [31:0]               pt_base_i,
  output logic                      ptw_req_valid_o,
  output logic [31:0]               ptw_req_addr_o,
  input  logic                      ptw_req_ready_i,
  input  logic                      ptw_resp_valid_i,
  input  logic [31:0]               ptw_resp_data_i,
  output logic                      wr_en_o,
  output logic [SET_INDEX_BITS-1:0] wr_set_o,
  output logic [WAY_BITS-1:0]       wr_way_o,
  output logic                      wr_valid_o,
  output logic [VPN_BITS-1:0]       wr_vpn_o,
  output logic [PPN_BITS-1:0]       wr_ppn_o,
  output logic [PERM_BITS-1:0]      wr_perms_o,
  output logic                      refill_done_o,
  output logic                      refill_fault_o,
  input  logic                      flush_req_i,
  output logic                      flush_done_o
);

  logic [2:0]                state_q, state_d;
  logic [VPN_BITS-1:0]       vpn_q, vpn_d;
  logic [ENTRY_BITS-1:0]     cnt_q, cnt_d, cnt_next;
  logic                      pend_q, pend_d;
  logic                      req_valid_q, req_valid_d;
  logic [31:0]               req_addr_q, req_addr_d;
  logic                      wr_en_q, wr_en_d;
  logic [SET_INDEX_BITS-1:0] wr_set_q, wr_set_d;
  logic [WAY_BITS-1:0]       wr_way_q, wr_way_d;
  logic                      wr_valid_q, wr_valid_d;
  logic [VPN_BITS-1:0]       wr_vpn_q, wr_vpn_d;
  logic [PPN_BITS-1:0]       wr_ppn_q, wr_ppn_d;
  logic [PERM_BITS-1:0]      wr_perms_q, wr_perms_d;
  logic                      done_q, done_d;
  logic                      fault_q, fault_d;
  logic                      fdone_q, fdone_d;
  logic                      commit, clear;
  logic [WAY_BITS-1:0]       victim_way;
  pte_t                      pte;
  logic                      unused_pte_bits;

  assign pte.ppn         = ptw_resp_data_i[PPN_MSB:PPN_LSB];
  assign pte.perms       = ptw_resp_data_i[PERM_MSB:PERM_LSB];
  assign pte.valid       = ptw_resp_data_i[PTE_V];
  assign unused_pte_bits = ^ptw_resp_data_i[PPN_LSB-1:PERM_MSB+1];
  assign cnt_next        = cnt_q + ENTRY_BITS'(1);

  tlb_refill_victim_sel u_victim (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_i       (vpn_q[SET_INDEX_BITS-1:0]),
    .set_valid_i (set_valid_i),
    .commit_i    (commit),
    .clear_i     (clear),
    .way_o       (victim_way)
  );

  // A pending or requested flush blocks new misses so the flush cannot be starved.
  assign miss_ready_o = (state_q == ST_IDLE) && !pend_q && !flush_req_i;

  always_comb begin
    state_d     = state_q;
    vpn_d       = vpn_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    wr_en_d     = 1'b0;
    wr_set_d    = wr_set_q;
    wr_way_d    = wr_way_q;
    wr_valid_d  = wr_valid_q;
    wr_vpn_d    = wr_vpn_q;
    wr_ppn_d    = wr_ppn_q;
    wr_perms_d  = wr_perms_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    fdone_d     = 1'b0;
    commit      = 1'b0;
    clear       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_req_i || pend_q) begin
          state_d    = ST_FLUSH;
          pend_d     = 1'b0;
          cnt_d      = '0;
          wr_en_d    = 1'b1;
          wr_valid_d = 1'b0;
          wr_set_d   = '0;
          wr_way_d   = '0;
        end else if (miss_valid_i) begin
          state_d     = ST_REQ;
          vpn_d       = miss_vpn_i;
          req_valid_d = 1'b1;
          req_addr_d  = pt_base_i + {10'd0, miss_vpn_i, 2'b00};
          wr_set_d    = miss_vpn_i[SET_INDEX_BITS-1:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == ENTRY_LAST) begin
          state_d = ST_IDLE;
          clear   = 1'b1;
        end else begin
          cnt_d                = cnt_next;
          wr_en_d              = 1'b1;
          wr_valid_d           = 1'b0;
          {wr_set_d, wr_way_d} = cnt_next;
          fdone_d              = (cnt_next == ENTRY_LAST);
        end
      end
      ST_REQ: begin
        pend_d = pend_q | flush_req_i;
        if (ptw_req_ready_i) begin
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        pend_d = pend_q | flush_req_i;
        if (ptw_resp_valid_i) begin
          state_d = ST_WRITE;
          done_d  = 1'b1;
          if (pte.valid) begin
            wr_en_d    = 1'b1;
            wr_valid_d = 1'b1;
            wr_vpn_d   = vpn_q;
            wr_ppn_d   = pte.ppn;
            wr_perms_d = pte.perms;
            wr_way_d   = victim_way;
            commit     = 1'b1;
          end else begin
            fault_d = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WRITE: begin
        pend_d  = pend_q | flush_req_i;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vpn_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_set_q    <= '0;
      wr_way_q    <= '0;
      wr_valid_q  <= 1'b0;
      wr_vpn_q    <= '0;
      wr_ppn_q    <= '0;
      wr_perms_q  <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      fdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      vpn_q       <= vpn_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      wr_en_q     <= wr_en_d;
      wr_set_q    <= wr_set_d;
      wr_way_q    <= wr_way_d;
      wr_valid_q  <= wr_valid_d;
      wr_vpn_q    <= wr_vpn_d;
      wr_ppn_q    <= wr_ppn_d;
      wr_perms_q  <= wr_perms_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      fdone_q     <= fdone_d;
    end
  end

  assign ptw_req_valid_o = req_valid_q;
  assign ptw_req_addr_o  = req_addr_q;
  assign wr_en_o         = wr_en_q;
  assign wr_set_o        = wr_set_q;
  assign wr_way_o        = wr_way_q;
  assign wr_valid_o      = wr_valid_q;
  assign wr_vpn_o        = wr_vpn_q;
  assign wr_ppn_o        = wr_ppn_q;
  assign wr_perms_o      = wr_perms_q;
  assign refill_done_o   = done_q;
  assign refill_fault_o  = fault_q;
  assign flush_done_o    = fdone_q;

endmodule

// File: tb/tb_tlb_refill.sv
// Randomized scoreboard bench for tlb_refill against a behavioural TLB-refill model.
module tb_tlb_refill;

  localparam int K_REQ   = 0;
  localparam int K_WR    = 1;
  localparam int K_DONE  = 2;
  localparam int K_FDONE = 3;

  logic        clk, rst_n;
  logic        miss_valid, miss_ready;
  logic [19:0] miss_vpn;
  logic [3:0]  set_valid;
  logic [31:0] pt_base, ptw_req_addr, ptw_resp_data;
  logic        ptw_req_valid, ptw_req_ready, ptw_resp_valid;
  logic        wr_en, wr_valid, refill_done, refill_fault, flush_req, flush_done;
  logic [3:0]  wr_set;
  logic [1:0]  wr_way, wr_perms;
  logic [19:0] wr_vpn, wr_ppn;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  set;
    logic [1:0]  way;
    logic        valid;
    logic [19:0] vpn;
    logic [19:0] ppn;
    logic [1:0]  perms;
    logic        fault;
  } exp_t;

  exp_t sbq[$];
  int   rr_m[16];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  tlb_refill dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid_i(miss_valid), .miss_vpn_i(miss_vpn), .miss_ready_o(miss_ready),
    .set_valid_i(set_valid), .pt_base_i(pt_base),
    .ptw_req_valid_o(ptw_req_valid), .ptw_req_addr_o(ptw_req_addr), .ptw_req_ready_i(ptw_req_ready),
    .ptw_resp_valid_i(ptw_resp_valid), .ptw_resp_data_i(ptw_resp_data),
    .wr_en_o(wr_en), .wr_set_o(wr_set), .wr_way_o(wr_way), .wr_valid_o(wr_valid),
    .wr_vpn_o(wr_vpn), .wr_ppn_o(wr_ppn), .wr_perms_o(wr_perms),
    .refill_done_o(refill_done), .refill_fault_o(refill_fault),
    .flush_req_i(flush_req), .flush_done_o(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int kind);
    exp_t e;
    e.kind = kind; e.addr = '0; e.set = '0; e.way = '0; e.valid = 1'b0;
    e.vpn = '0; e.ppn = '0; e.perms = '0; e.fault = 1'b0;
    return e;
  endfunction

  // Reference replacement: first free way, otherwise the set's rotating pointer.
  function automatic logic [1:0] model_victim(input int set, input logic [3:0] sv);
    int w;
    for (int i = 0; i < 4; i++) if (!sv[i]) return 2'(i);
    w = rr_m[set];
    rr_m[set] = (w + 1) % 4;
    return 2'(w);
  endfunction

  task automatic model_reset_rr();
    for (int s = 0; s < 16; s++) rr_m[s] = 0;
  endtask

  task automatic push_flush();
    exp_t e;
    for (int n = 0; n < 64; n++) begin
      e = mk(K_WR); e.set = 4'(n / 4); e.way = 2'(n % 4); e.valid = 1'b0;
      sbq.push_back(e);
    end
    sbq.push_back(mk(K_FDONE));
    model_reset_rr();
  endtask

  task automatic pop_chk(input int kind, input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s unexpected actual=present required=none", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_order"}, 64'(kind), 64'(e.kind));
      if (kind == e.kind && kind == K_REQ) chk("req_addr", ptw_req_addr, e.addr);
      if (kind == e.kind && kind == K_WR) begin
        chk("wr_set_way_valid", {wr_set, wr_way, wr_valid}, {e.set, e.way, e.valid});
        if (e.valid) chk("wr_vpn_ppn_perms", {wr_vpn, wr_ppn, wr_perms}, {e.vpn, e.ppn, e.perms});
      end
      if (kind == e.kind && kind == K_DONE) chk("refill_fault", refill_fault, e.fault);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents an event.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (ptw_req_valid && ptw_req_ready) pop_chk(K_REQ, "ptw_req");
        if (wr_en) pop_chk(K_WR, "wr_en");
        if (refill_done) pop_chk(K_DONE, "refill_done");
        if (flush_done) pop_chk(K_FDONE, "flush_done");
        if (!refill_done) chk("fault_without_done", refill_fault, 1'b0);
      end
    end
  end

  task automatic refill(input logic [31:0] base, input logic [19:0] vpn, input logic [3:0] sv,
                        input logic [31:0] pte, input int rdly, input int pdly,
                        input bit flush_in_wait, input bit poke_miss);
    int          n;
    exp_t        e;
    logic [31:0] exp_addr;
    @(posedge clk); #1;
    miss_valid = 1'b1; miss_vpn = vpn; pt_base = base; set_valid = sv;
    n = 0;
    while (!miss_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("miss_ready_wait", miss_ready, 1'b1);
    exp_addr = base + {12'd0, vpn} * 32'd4;
    e = mk(K_REQ); e.addr = exp_addr; sbq.push_back(e);
    @(posedge clk); #1;
    miss_valid = 1'b0;
    chk("req_valid_next_cycle", ptw_req_valid, 1'b1);
    chk("miss_ready_busy", miss_ready, 1'b0);
    for (int i = 0; i < rdly; i++) begin
      chk("req_hold_valid", ptw_req_valid, 1'b1);
      chk("req_hold_addr", ptw_req_addr, exp_addr);
      @(posedge clk); #1;
    end
    ptw_req_ready = 1'b1;
    @(posedge clk); #1;
    ptw_req_ready = 1'b0;
    chk("req_dropped", ptw_req_valid, 1'b0);
    if (flush_in_wait) flush_req = 1'b1;
    if (poke_miss) begin
      miss_valid = 1'b1; miss_vpn = ~vpn;
      chk("miss_ready_in_wait", miss_ready, 1'b0);
      @(posedge clk); #1;
      miss_valid = 1'b0;
    end
    for (int i = 0; i < pdly; i++) begin @(posedge clk); #1; end
    if (pte[0]) begin
      e = mk(K_WR); e.set = vpn[3:0]; e.valid = 1'b1; e.vpn = vpn;
      e.ppn = pte[31:12]; e.perms = pte[2:1];
      e.way = model_victim(int'(vpn[3:0]), sv);
      sbq.push_back(e);
    end
    e = mk(K_DONE); e.fault = ~pte[0]; sbq.push_back(e);
    ptw_resp_valid = 1'b1; ptw_resp_data = pte;
    @(posedge clk); #1;
    ptw_resp_valid = 1'b0; flush_req = 1'b0;
    chk("done_latency", refill_done, 1'b1);
    if (flush_in_wait) push_flush();
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin @(posedge clk); n++; end
    @(posedge clk); #1;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] r, p, b;
    logic [3:0]  sv;
    int          n;
    rst_n = 1'b0; miss_valid = 1'b0; miss_vpn = '0; set_valid = '0; pt_base = '0;
    ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_data = '0; flush_req = 1'b0;
    model_reset_rr();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ctrl", {ptw_req_valid, wr_en, wr_valid, refill_done, refill_fault, flush_done}, 6'd0);
    chk("reset_data", {wr_set, wr_way, wr_perms, wr_vpn, wr_ppn}, 48'd0);
    chk("reset_addr", ptw_req_addr, 32'd0);
    chk("reset_miss_ready", miss_ready, 1'b1);
    mon_en = 1'b1;

    refill(32'h1000_0000, 20'h12345, 4'b0000, 32'h5432_1007, 0, 0, 1'b0, 1'b0);
    refill(32'h1000_0000, 20'h0ABCE, 4'b1111, 32'h7777_7006, 0, 1, 1'b0, 1'b0);
    refill(32'h1000_0000, 20'h00A03, 4'b0101, 32'h0BEEF_003, 1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      refill(32'h2000_0000, {16'(k + 7), 4'hE}, 4'b1111, {20'(k + 32'h100), 12'h005}, 0, 0, 1'b0, 1'b0);
    refill(32'hFFFF_FFF0, 20'hFFFFF, 4'b0111, 32'hCAFE_0003, 5, 2, 1'b0, 1'b1);
    refill(32'h0000_4000, 20'h00031, 4'b0000, 32'h1357_9007, 0, 3, 1'b1, 1'b0);
    drain();

    // Level flush held across flush_done must trigger a second full pass.
    @(posedge clk); #1;
    flush_req = 1'b1;
    push_flush(); push_flush();
    n = 0;
    while (!flush_done && n < 200) begin @(negedge clk); n++; end
    chk("first_flush_done_seen", flush_done, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    flush_req = 1'b0;
    drain();

    for (int it = 0; it < 40; it++) begin
      r = $urandom; p = $urandom; b = $urandom;
      sv = 4'($urandom);
      if ($urandom_range(0, 2) == 0) sv = 4'b1111;
      p[0] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        ptw_resp_valid = 1'b1; ptw_resp_data = r;
        @(posedge clk); #1;
        ptw_resp_valid = 1'b0;
      end
      refill(b, {r[19:4], 2'b10, 2'($urandom_range(0, 3))}, sv, p,
             $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 1'b0);
    end
    drain();

    // Reset in the middle of a flush: no further writes and no flush_done.
    mon_en = 1'b0;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("flush_active_before_reset", wr_en, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("wr_en_after_reset", wr_en, 1'b0);
    chk("flush_done_after_reset", flush_done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset_rr();
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (wr_en || flush_done || refill_done) n++;
    end
    chk("quiet_after_reset", 64'(n), 64'd0);
    chk("miss_ready_after_reset", miss_ready, 1'b1);
    mon_en = 1'b1;
    refill(32'h3000_0000, 20'h0000E, 4'b1111, 32'h2468_A007, 0, 0, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
